// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline definitions for the hazard scoreboard and the decoder.
//   lat_class_t   : producer latency classes (ALU / load / multi-cycle MUL)
//   OP_*          : RV32I major opcodes used to derive *_use and class signals
//   sb_cnt_width  : width of one scoreboard countdown for the given latencies
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MUL  = 2'd2
    } lat_class_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // A counter must hold the longest latency plus one, so the slowest
    // writer can still be loaded without wrapping.
    function automatic int sb_cnt_width(input int loadLat, input int mulLat);
        int maxLat;
        maxLat = (loadLat > mulLat) ? loadLat : mulLat;
        return $clog2(maxLat + 2);
    endfunction

endpackage

// File: rtl/sb_entry.sv
// -----------------------------------------------------------------------------
// sb_entry
// One scoreboard slot: a countdown of cycles until the register's newest
// in-flight writer can be consumed.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_hold       : pipeline frozen, keep the count
//   i_load       : a writer of this register issues this cycle
//   i_load_val   : latency + 1 of that writer
//   o_cnt        : current count (0 = no pending writer)
// -----------------------------------------------------------------------------
module sb_entry
    import pipe_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_hold,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic [CW-1:0] o_cnt
);

    logic [CW-1:0] r_cnt;

    // Hold beats load: a frozen pipe issues nothing, so no writer can
    // arrive. A new writer overwrites any older pending one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_hold) begin
            r_cnt <= r_cnt;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Per-register countdown scoreboard that decides whether the instruction in
// ID may issue, and drives the PC / IF/ID / ID/EX controls accordingly.
//   clk, rst_n        : clock, asynchronous active-low reset
//   id_valid          : ID holds a real instruction
//   id_rs1/2, *_use   : source registers and whether they are read
//   id_is_branch      : conditional branch sitting in ID
//   id_rd, id_rd_we   : destination register and write enable
//   id_lat_class      : 0 ALU, 1 load, 2 MUL, 3 treated as ALU
//   pipe_freeze       : downstream busy, whole pipe holds
//   redirect          : ID instruction is being killed this cycle
//   perf_clr          : synchronous clear of stall_cycles
//   pc_write          : PC update enable
//   if_id_write       : IF/ID register enable
//   id_ex_flush       : insert a bubble into ID/EX
//   hazard_stall      : data-hazard stall this cycle
//   stall_cycles      : saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int RA_W         = 5,
    parameter int LOAD_LAT     = 1,
    parameter int MUL_LAT      = 2,
    parameter int BRANCH_IN_ID = 1,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic              id_rs1_use,
    input  logic              id_rs2_use,
    input  logic              id_is_branch,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_rd_we,
    input  logic [1:0]        id_lat_class,
    input  logic              pipe_freeze,
    input  logic              redirect,
    input  logic              perf_clr,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_flush,
    output logic              hazard_stall,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int CW = sb_cnt_width(LOAD_LAT, MUL_LAT);

    logic [CW-1:0]     w_cnt [NREG];
    logic [CW-1:0]     w_thr;
    logic [CW-1:0]     w_lat_p1;
    logic              w_need1;
    logic              w_need2;
    logic              w_blk1;
    logic              w_blk2;
    logic              w_issue;
    logic [PERF_W-1:0] r_stall_cycles;

    assign w_cnt[0] = '0;

    // A branch resolved in ID needs its operand a cycle earlier than an EX
    // consumer, so it tolerates one less remaining cycle on the counter.
    assign w_thr   = (BRANCH_IN_ID != 0 && id_is_branch) ? '0 : CW'(1);
    assign w_need1 = id_rs1_use && (id_rs1 != '0);
    assign w_need2 = id_rs2_use && (id_rs2 != '0);
    assign w_blk1  = w_need1 && (w_cnt[id_rs1] > w_thr);
    assign w_blk2  = w_need2 && (w_cnt[id_rs2] > w_thr);

    assign hazard_stall = id_valid && !redirect && (w_blk1 || w_blk2);
    assign w_issue      = id_valid && !redirect && !hazard_stall && !pipe_freeze;

    // Counter load value by producer class; the reserved class behaves as ALU.
    always_comb begin
        w_lat_p1 = CW'(1);
        case (id_lat_class)
            LAT_LOAD: w_lat_p1 = CW'(LOAD_LAT + 1);
            LAT_MUL:  w_lat_p1 = CW'(MUL_LAT + 1);
            default:  w_lat_p1 = CW'(1);
        endcase
    end

    // Freeze holds everything but still reports the hazard; otherwise a
    // hazard holds PC and IF/ID and bubbles ID/EX.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_flush = 1'b0;
        if (pipe_freeze) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (hazard_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // x0 has no slot; its count is the constant zero above.
    for (genvar r = 1; r < NREG; r++) begin : g_entry
        logic w_load;
        assign w_load = w_issue && id_rd_we && (id_rd == RA_W'(r));
        sb_entry #(.CW(CW)) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_hold     (pipe_freeze),
            .i_load     (w_load),
            .i_load_val (w_lat_p1),
            .o_cnt      (w_cnt[r])
        );
    end

    // Clear beats increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (perf_clr) begin
            r_stall_cycles <= '0;
        end else if (hazard_stall && !pipe_freeze && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       idValid = 1'b0;
    logic [4:0] idRs1 = '0;
    logic [4:0] idRs2 = '0;
    logic       idRs1Use = 1'b0;
    logic       idRs2Use = 1'b0;
    logic       idIsBranch = 1'b0;
    logic [4:0] idRd = '0;
    logic       idRdWe = 1'b0;
    logic [1:0] idLatClass = '0;
    logic       pipeFreeze = 1'b0;
    logic       redirect = 1'b0;
    logic       perfClr = 1'b0;

    logic        pcWriteA, ifIdWriteA, idExFlushA, hazardStallA;
    logic [15:0] stallCyclesA;
    logic        pcWriteB, ifIdWriteB, idExFlushB, hazardStallB;
    logic [2:0]  stallCyclesB;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: each register remembers the "active time" (count of
    // non-frozen cycles) from which its newest result is usable by EX.
    localparam int BR_ID_M[2]    = '{1, 0};
    localparam int LOAD_LAT_M[2] = '{1, 3};
    localparam int MUL_LAT_M     = 2;
    localparam longint PERF_MAX[2] = '{65535, 7};
    localparam longint NEVER     = -1000000;

    longint readyAt [2][32];
    longint activeTime = 0;
    longint perfModel [2];
    bit     expStall [2];
    bit     obsStallA, obsStallB;

    always #5 clk = ~clk;

    hazard_scoreboard u_dutA (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid),
        .id_rs1(idRs1), .id_rs2(idRs2), .id_rs1_use(idRs1Use), .id_rs2_use(idRs2Use),
        .id_is_branch(idIsBranch), .id_rd(idRd), .id_rd_we(idRdWe),
        .id_lat_class(idLatClass), .pipe_freeze(pipeFreeze), .redirect(redirect),
        .perf_clr(perfClr), .pc_write(pcWriteA), .if_id_write(ifIdWriteA),
        .id_ex_flush(idExFlushA), .hazard_stall(hazardStallA), .stall_cycles(stallCyclesA)
    );

    hazard_scoreboard #(.LOAD_LAT(3), .BRANCH_IN_ID(0), .PERF_W(3)) u_dutB (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid),
        .id_rs1(idRs1), .id_rs2(idRs2), .id_rs1_use(idRs1Use), .id_rs2_use(idRs2Use),
        .id_is_branch(idIsBranch), .id_rd(idRd), .id_rd_we(idRdWe),
        .id_lat_class(idLatClass), .pipe_freeze(pipeFreeze), .redirect(redirect),
        .perf_clr(perfClr), .pc_write(pcWriteB), .if_id_write(ifIdWriteB),
        .id_ex_flush(idExFlushB), .hazard_stall(hazardStallB), .stall_cycles(stallCyclesB)
    );

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            perfModel[k] = 0;
            for (int r = 0; r < 32; r++) readyAt[k][r] = NEVER;
        end
    endtask

    function automatic bit modelStall(int k);
        longint extra;
        bit blocked;
        extra = (BR_ID_M[k] != 0 && idIsBranch) ? 1 : 0;
        blocked = 1'b0;
        if (idRs1Use && idRs1 != 0 && activeTime < readyAt[k][idRs1] + extra) blocked = 1'b1;
        if (idRs2Use && idRs2 != 0 && activeTime < readyAt[k][idRs2] + extra) blocked = 1'b1;
        return idValid && !redirect && blocked;
    endfunction

    function automatic longint modelLat(int k);
        case (idLatClass)
            2'd1:    return LOAD_LAT_M[k];
            2'd2:    return MUL_LAT_M;
            default: return 0;
        endcase
    endfunction

    // One clock with the currently driven inputs: compare mid-cycle, then
    // advance the model across the rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        for (int k = 0; k < 2; k++) expStall[k] = modelStall(k);
        checkOutput("stallA", hazardStallA, expStall[0]);
        checkOutput("stallB", hazardStallB, expStall[1]);
        checkOutput("pcWriteA", pcWriteA, !pipeFreeze && !expStall[0]);
        checkOutput("ifIdWriteA", ifIdWriteA, !pipeFreeze && !expStall[0]);
        checkOutput("flushA", idExFlushA, !pipeFreeze && expStall[0]);
        checkOutput("flushB", idExFlushB, !pipeFreeze && expStall[1]);
        checkOutput("perfA", stallCyclesA, perfModel[0]);
        checkOutput("perfB", stallCyclesB, perfModel[1]);
        obsStallA = hazardStallA;
        obsStallB = hazardStallB;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (perfClr) perfModel[k] = 0;
            else if (expStall[k] && !pipeFreeze && perfModel[k] < PERF_MAX[k]) perfModel[k]++;
            if (idValid && !redirect && !expStall[k] && !pipeFreeze && idRdWe && idRd != 0)
                readyAt[k][idRd] = activeTime + modelLat(k) + 1;
        end
        if (!pipeFreeze) activeTime++;
        #1;
    endtask

    task automatic setInstr(input int rs1, input int rs2, input bit u1, input bit u2,
                            input bit br, input int rd, input bit we, input int cls);
        idValid = 1'b1;
        idRs1 = 5'(rs1); idRs2 = 5'(rs2); idRs1Use = u1; idRs2Use = u2;
        idIsBranch = br; idRd = 5'(rd); idRdWe = we; idLatClass = 2'(cls);
    endtask

    task automatic drain();
        idValid = 1'b0; idRdWe = 1'b0; idRs1Use = 1'b0; idRs2Use = 1'b0; idIsBranch = 1'b0;
        repeat (6) applyStimulus();
    endtask

    // Hold the consumer in ID until neither design stalls; count each one's stalls.
    task automatic runConsumer(input string tag, input int wantA, input int wantB);
        int nA, nB;
        bit done;
        nA = 0; nB = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            applyStimulus();
            if (obsStallA) nA++;
            if (obsStallB) nB++;
            if (!obsStallA && !obsStallB) done = 1'b1;
        end
        if (!done) checkOutput({tag, "_timeout"}, 1, 0);
        checkOutput({tag, "_stallsA"}, nA, wantA);
        checkOutput({tag, "_stallsB"}, nB, wantB);
    endtask

    initial begin
        int perfBefore;
        modelReset();
        #12;
        checkOutput("rst_pcWrite", pcWriteA, 1);
        checkOutput("rst_ifIdWrite", ifIdWriteA, 1);
        checkOutput("rst_flush", idExFlushA, 0);
        checkOutput("rst_stall", hazardStallA, 0);
        checkOutput("rst_perf", stallCyclesA, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drain();

        // addi x5 ; beq x5, x0
        setInstr(1, 0, 1, 0, 0, 5, 1, 0); applyStimulus();
        setInstr(5, 0, 1, 1, 1, 0, 0, 0); runConsumer("alu_br", 1, 0);
        drain();
        // lw x6 ; add x7, x6, x1
        setInstr(1, 0, 1, 0, 0, 6, 1, 1); applyStimulus();
        setInstr(6, 1, 1, 1, 0, 7, 1, 0); runConsumer("ld_ex", 1, 3);
        drain();
        // lw x6 ; beq x6, x0
        setInstr(1, 0, 1, 0, 0, 6, 1, 1); applyStimulus();
        setInstr(6, 0, 1, 1, 1, 0, 0, 0); runConsumer("ld_br", 2, 3);
        drain();
        // mul x8 ; sub x9, x8, x1
        perfBefore = stallCyclesA;
        setInstr(2, 3, 1, 1, 0, 8, 1, 2); applyStimulus();
        setInstr(8, 1, 1, 1, 0, 9, 1, 0); runConsumer("mul_ex", 2, 2);
        checkOutput("mul_perf_delta", stallCyclesA - perfBefore, 2);
        drain();
        // lw x6 ; freeze 4 cycles with consumer waiting ; release
        setInstr(1, 0, 1, 0, 0, 6, 1, 1); applyStimulus();
        setInstr(6, 1, 1, 1, 0, 7, 1, 0);
        pipeFreeze = 1'b1;
        repeat (4) applyStimulus();
        pipeFreeze = 1'b0;
        runConsumer("frz_ex", 1, 3);
        drain();
        // writer to x0 (as a load) ; reader of x0
        setInstr(1, 0, 1, 0, 0, 0, 1, 1); applyStimulus();
        setInstr(0, 0, 1, 1, 1, 10, 1, 0); runConsumer("x0", 0, 0);
        drain();
        // lw x6 ; addi x6 overwrite ; reader of x6
        setInstr(1, 0, 1, 0, 0, 6, 1, 1); applyStimulus();
        setInstr(1, 0, 1, 0, 0, 6, 1, 0); applyStimulus();
        setInstr(6, 0, 1, 0, 0, 11, 1, 0); runConsumer("ovw", 0, 0);
        drain();
        // perf_clr together with a stall cycle
        setInstr(1, 0, 1, 0, 0, 6, 1, 1); applyStimulus();
        setInstr(6, 0, 1, 0, 0, 12, 1, 0);
        perfClr = 1'b1; applyStimulus(); perfClr = 1'b0;
        checkOutput("perf_clr_win", stallCyclesA, 0);
        drain();
        // asynchronous reset while x6 has a pending load
        setInstr(1, 0, 1, 0, 0, 6, 1, 1); applyStimulus();
        setInstr(6, 1, 1, 1, 0, 7, 1, 0);
        #2;
        checkOutput("pre_rst_stall", hazardStallA, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_stall", hazardStallA, 0);
        checkOutput("arst_pcWrite", pcWriteA, 1);
        checkOutput("arst_ifIdWrite", ifIdWriteA, 1);
        checkOutput("arst_flush", idExFlushA, 0);
        checkOutput("arst_perfB", stallCyclesB, 0);
        idValid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        modelReset();
        setInstr(6, 1, 1, 1, 0, 7, 1, 0); runConsumer("post_rst", 0, 0);
        drain();

        // Randomized traffic; a stalled or frozen instruction stays in ID.
        for (int i = 0; i < 400; i++) begin
            if (i == 0 || !(obsStallA || pipeFreeze) || redirect) begin
                bit br;
                br = ($urandom_range(0, 3) == 0);
                setInstr($urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 1), $urandom_range(0, 1), br,
                         $urandom_range(0, 7), !br && ($urandom_range(0, 3) != 0),
                         $urandom_range(0, 3));
                idValid = ($urandom_range(0, 7) != 0);
            end
            pipeFreeze = ($urandom_range(0, 7) == 0);
            redirect   = ($urandom_range(0, 9) == 0);
            perfClr    = ($urandom_range(0, 31) == 0);
            applyStimulus();
        end
        pipeFreeze = 1'b0; redirect = 1'b0; perfClr = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
